// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel receive FIFO.
// Optional trailing even-parity bit per frame is enabled by defining DESER_PARITY_EN.
package deser_pkg;

`ifdef DESER_PARITY_EN
  localparam int PAR_BIT_EN = 1;
`else
  localparam int PAR_BIT_EN = 0;
`endif

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_fifo_if.sv
// Output word stream from deser_fifo to its consumer (valid/ready).
// Carries the per-word parity error flag when DESER_PARITY_EN is defined.
interface deser_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

`ifdef DESER_PARITY_EN
  logic out_perr;

  modport master (output out_data, out_valid, out_perr, input out_ready);
  modport slave  (input out_data, out_valid, out_perr, output out_ready);
`else
  modport master (output out_data, out_valid, input out_ready);
  modport slave  (input out_data, out_valid, output out_ready);
`endif
endinterface

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module sync_fifo
  import deser_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int PTR_W = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   fill_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every branch of a comb block must assign its outputs; the default here prevents a latch.
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose so the head word reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/deser_fifo.sv
// Serial-to-parallel word assembler feeding a DEPTH-entry output FIFO with
// frame resync and sticky overflow; DESER_PARITY_EN adds a trailing even-parity bit.
module deser_fifo
  import deser_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 4,
  parameter int  MSB_FIRST = 1,
  localparam int CNT_W     = clog2_min1(WIDTH + PAR_BIT_EN),
  localparam int PTR_W     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serial_in,
  input  logic              shift_en,
  input  logic              tick,
  input  logic              frame_start,
  deser_fifo_if.master      out_if,
  output logic              overflow,
  input  logic              clear_ovf,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [PTR_W:0]    fill
);

  typedef logic [WIDTH-1:0] word_t;

  localparam int ENTRY_W = WIDTH + PAR_BIT_EN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH + PAR_BIT_EN - 1);

  word_t              sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               sample, push, pop, drop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] entry, head;

  assign sample   = shift_en && tick;
  assign sr_shift = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], serial_in}
                                     : {serial_in, sr_q[WIDTH-1:1]};

`ifdef DESER_PARITY_EN
  // The last sample is the parity bit: the word is already complete in sr_q.
  assign entry = {(^sr_q) ^ serial_in, sr_q};
`else
  assign entry = sr_shift;
`endif

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (sample) begin
      if (frame_start) begin
        sr_d  = (MSB_FIRST != 0) ? {{(WIDTH-1){1'b0}}, serial_in}
                                 : {serial_in, {(WIDTH-1){1'b0}}};
        cnt_d = CNT_W'(1);
      end else if (cnt_q == LAST) begin
        push  = 1'b1;
        cnt_d = '0;
`ifndef DESER_PARITY_EN
        sr_d  = sr_shift;
`endif
      end else begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign pop  = out_if.out_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // A drop sets the flag even if clear_ovf is asserted in the same cycle.
  assign ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .din_i   (entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  assign out_if.out_data  = head[WIDTH-1:0];
  assign out_if.out_valid = !fifo_empty;
`ifdef DESER_PARITY_EN
  assign out_if.out_perr  = head[WIDTH];
`endif
  assign overflow = ovf_q;
  assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_deser_fifo.sv
// Directed bench for deser_fifo: an MSB-first and an LSB-first instance share one
// serial stream; a vector table covers word assembly, hand sequences the corner cases.
module tb_deser_fifo;
  import deser_pkg::*;

  localparam int CNT_W = clog2_min1(32 + PAR_BIT_EN);

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic serial_in = 1'b0, shift_en = 1'b0, tick = 1'b0, frame_start = 1'b0;
  logic clear_ovf = 1'b0, out_ready = 1'b0;
  logic ovf_m, ovf_l;
  logic [CNT_W-1:0] bc_m, bc_l;
  logic [2:0] fill_m, fill_l;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  deser_fifo_if #(.WIDTH(32)) if_m ();
  deser_fifo_if #(.WIDTH(32)) if_l ();
  assign if_m.out_ready = out_ready;
  assign if_l.out_ready = out_ready;

  deser_fifo #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .shift_en(shift_en),
    .tick(tick), .frame_start(frame_start), .out_if(if_m), .overflow(ovf_m),
    .clear_ovf(clear_ovf), .bit_cnt(bc_m), .fill(fill_m));

  deser_fifo #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .shift_en(shift_en),
    .tick(tick), .frame_start(frame_start), .out_if(if_l), .overflow(ovf_l),
    .clear_ovf(clear_ovf), .bit_cnt(bc_l), .fill(fill_l));

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_m;
    logic [31:0] exp_l;
  } vec_t;

  vec_t        vecs  [4];
  logic [31:0] words [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // One bit period of four clocks: a sample cycle, then idle cycles that
  // raise tick without shift_en and frame_start without tick (neither is a sample).
  task automatic send_bit(input logic b, input logic fs, input logic rdy, input logic chk_lat);
    serial_in = b; shift_en = 1'b1; tick = 1'b1; frame_start = fs; out_ready = rdy;
    @(posedge clk); #1;
    frame_start = 1'b0; out_ready = 1'b0;
    if (chk_lat) begin
      check("lat_valid_m", {31'd0, if_m.out_valid}, 32'd1);
      check("lat_valid_l", {31'd0, if_l.out_valid}, 32'd1);
    end
    shift_en = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    shift_en = 1'b1; tick = 1'b0; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Word sent MSB first on the wire; with parity enabled pbit trails the word.
  task automatic send_word(input logic [31:0] w, input logic pbit, input logic chk_lat,
                           input logic fs_first, input logic rdy_last);
`ifdef DESER_PARITY_EN
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i], fs_first && (i == 31), 1'b0, 1'b0);
      if (fs_first && (i == 31)) check("fs_bitcnt", 32'(bc_m), 32'd1);
    end
    if (chk_lat) check("lat_pre", {31'd0, if_m.out_valid}, 32'd0);
    send_bit(pbit, 1'b0, rdy_last, chk_lat);
`else
    for (int i = 31; i >= 1; i--) begin
      send_bit(w[i], fs_first && (i == 31), 1'b0, 1'b0);
      if (fs_first && (i == 31)) check("fs_bitcnt", 32'(bc_m), 32'd1);
    end
    if (chk_lat) check("lat_pre", {31'd0, if_m.out_valid}, 32'd0);
    if (pbit === 1'bx) check("pbit_defined", 32'd0, 32'd1);
    send_bit(w[0], 1'b0, rdy_last, chk_lat);
`endif
  endtask

  task automatic pop_check(input string name, input logic [31:0] em, input logic [31:0] el);
    check({name, "_valid"}, {31'd0, if_m.out_valid}, 32'd1);
    check({name, "_m"}, if_m.out_data, em);
    check({name, "_l"}, if_l.out_data, el);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hF0F0_A5A5};
    vecs[1] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    vecs[2] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_FFFF};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h1E6A_2C48};
    words[0] = 32'h1111_0001;
    words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003;
    words[3] = 32'h4444_0004;
    words[4] = 32'h5555_0005;

    // Reset values.
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, if_m.out_valid}, 32'd0);
    check("rst_fill", 32'(fill_m), 32'd0);
    check("rst_bitcnt", 32'(bc_m), 32'd0);
    check("rst_data", if_m.out_data, 32'd0);
    check("rst_ovf", {31'd0, ovf_m}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Word assembly in both bit orders, with first-word latency.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].word, ^vecs[i].word, 1'b1, 1'b0, 1'b0);
      check("vec_fill", 32'(fill_m), 32'd1);
`ifdef DESER_PARITY_EN
      check("vec_perr", {31'd0, if_m.out_perr}, 32'd0);
`endif
      pop_check("vec", vecs[i].exp_m, vecs[i].exp_l);
      check("vec_empty", {31'd0, if_m.out_valid}, 32'd0);
    end

    // Frame resync after 10 stale bits.
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    check("stale_bitcnt", 32'(bc_m), 32'd10);
    send_word(32'hA5A5_0F0F, ^32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0);
    check("fs_fill_m", 32'(fill_m), 32'd1);
    check("fs_fill_l", 32'(fill_l), 32'd1);
    pop_check("fs", 32'hA5A5_0F0F, 32'hF0F0_A5A5);
    check("fs_empty", 32'(fill_m), 32'd0);

    // Overflow: fifth word dropped, flag sticky until cleared.
    for (int k = 0; k < 4; k++) send_word(words[k], ^words[k], 1'b0, 1'b0, 1'b0);
    check("full_fill", 32'(fill_m), 32'd4);
    check("full_no_ovf", {31'd0, ovf_m}, 32'd0);
    send_word(words[4], ^words[4], 1'b0, 1'b0, 1'b0);
    check("ovf_fill", 32'(fill_m), 32'd4);
    check("ovf_set_m", {31'd0, ovf_m}, 32'd1);
    check("ovf_set_l", {31'd0, ovf_l}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_sticky", {31'd0, ovf_m}, 32'd1);
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    check("ovf_clear", {31'd0, ovf_m}, 32'd0);
    for (int k = 0; k < 4; k++) pop_check("ovf_drain", words[k], bitrev(words[k]));
    check("ovf_drained", 32'(fill_m), 32'd0);

    // Push into a full FIFO in the same cycle as a pop.
    for (int k = 0; k < 4; k++) send_word(words[k], ^words[k], 1'b0, 1'b0, 1'b0);
    send_word(words[4], ^words[4], 1'b0, 1'b0, 1'b1);
    check("pp_no_ovf", {31'd0, ovf_m}, 32'd0);
    check("pp_fill", 32'(fill_m), 32'd4);
    for (int k = 1; k < 5; k++) pop_check("pp_drain", words[k], bitrev(words[k]));
    check("pp_drained", 32'(fill_l), 32'd0);

    // Asynchronous reset mid-word with two words queued.
    send_word(words[0], ^words[0], 1'b0, 1'b0, 1'b0);
    send_word(words[1], ^words[1], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill_m), 32'd2);
    check("pre_rst_bitcnt", 32'(bc_m), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, if_m.out_valid}, 32'd0);
    check("arst_fill", 32'(fill_m), 32'd0);
    check("arst_bitcnt", 32'(bc_m), 32'd0);
    check("arst_data", if_m.out_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_word(vecs[3].word, ^vecs[3].word, 1'b1, 1'b0, 1'b0);
    pop_check("post_rst", vecs[3].exp_m, vecs[3].exp_l);

`ifdef DESER_PARITY_EN
    send_word(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    check("perr_bad", {31'd0, if_m.out_perr}, 32'd1);
    pop_check("perr_bad", 32'h0000_0001, 32'h8000_0000);
    send_word(32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    check("perr_good", {31'd0, if_m.out_perr}, 32'd0);
    pop_check("perr_good", 32'h0000_0001, 32'h8000_0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
